snes_serial_out: RTL



---
 rtl/snes_pkg.sv | 36 +++
 rtl/snes_sync_edge.sv | 36 +++
 rtl/snes_serial_out.sv | 124 ++++++++++++
 3 files changed

// File: rtl/snes_pkg.sv
// Shared constants, state type and frame helper for the SNES controller
// serial output block.
package snes_pkg;

  localparam int SNES_BUTTON_BITS = 12;
  localparam int SNES_FRAME_BITS  = 16;

  // Button positions in the parallel word (and in serial bit order)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } snes_state_t;

  // Upper four frame bits are unused ID bits and read back as "not pressed".
  function automatic logic [SNES_FRAME_BITS-1:0] frame_load(
    input logic [SNES_BUTTON_BITS-1:0] b
  );
    return {{(SNES_FRAME_BITS-SNES_BUTTON_BITS){1'b0}}, b};
  endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-flop synchronizer followed by an edge-detect flop.
// Ports:
//   clk_i    system clock
//   reset_n  synchronous active-low reset; all flops load RST_VAL
//   din      asynchronous input pin
//   rise     one-cycle pulse on a synchronized 0->1 transition
//   fall     one-cycle pulse on a synchronized 1->0 transition
module snes_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Resetting to the pin's idle level keeps reset release edge-free.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/snes_serial_out.sv
// Presents a 12-bit button word to a SNES console as a standard controller.
// Ports:
//   clk_i       system clock (2.08 MHz)
//   reset_n     synchronous active-low reset
//   buttons     parallel buttons, 1 = pressed (bit0 B ... bit11 R)
//   snes_latch  console latch pin, async, active-high
//   snes_clk    console clock pin, async, idles high
//   snes_data   serial data to console, active-low
//   busy        high while latching or shifting
//   frame_done  one-cycle pulse after bit 15 has been shifted out
module snes_serial_out
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2080
) (
  input  logic                        clk_i,
  input  logic                        reset_n,
  input  logic [SNES_BUTTON_BITS-1:0] buttons,
  input  logic                        snes_latch,
  input  logic                        snes_clk,
  output logic                        snes_data,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic latch_rise, latch_fall, clk_rise, clk_fall_unused;

  snes_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch_sync (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .din     (snes_latch),
    .rise    (latch_rise),
    .fall    (latch_fall)
  );

  snes_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .din     (snes_clk),
    .rise    (clk_rise),
    .fall    (clk_fall_unused)
  );

  snes_state_t                 state_q, state_d;
  logic [SNES_FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [4:0]                  bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    // A new latch restarts the frame from any state and beats a
    // coincident clock edge.
    if (latch_rise) begin
      state_d   = LATCH;
      shreg_d   = frame_load(buttons);
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      case (state_q)
        LATCH: begin
          // Parallel mode: track the buttons until the latch drops.
          shreg_d   = frame_load(buttons);
          bit_cnt_d = '0;
          tmo_d     = '0;
          if (latch_fall) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 5'd1;
            tmo_d     = '0;
            if (bit_cnt_q == 5'(SNES_FRAME_BITS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
            // Console went silent mid-frame: abandon without frame_done.
            if (tmo_q >= TMO_LAST) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      LATCH, SHIFT: snes_data = ~shreg_q[0];
      DONE:         snes_data = 1'b0;
      default:      snes_data = 1'b1;
    endcase
  end

  assign busy       = (state_q == LATCH) || (state_q == SHIFT);
  assign frame_done = done_q;

endmodule
